// File: rtl/present_pkg.sv
// present_pkg: shared widths, default headers and framer state encoding
package present_pkg;
  localparam int PT_W = 16;
  localparam int KEY_W = 20;
  localparam logic [7:0] KEY_HDR_DEF = 8'hA5;
  localparam logic [7:0] PT_HDR_DEF = 8'h5A;
  typedef enum logic [2:0] {IDLE, KEY, PT, DROP, HOLD} state_e;
endpackage

// File: rtl/present_input_framer.sv
// present_input_framer: byte-serial command framer feeding stable key/plaintext to PRESENT
module present_input_framer
  import present_pkg::*;
#(
  parameter logic [7:0] KEY_HDR = KEY_HDR_DEF,
  parameter logic [7:0] PT_HDR = PT_HDR_DEF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [KEY_W-1:0] master_key,
  output logic [PT_W-1:0]  ptext,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic             key_loaded,
  output logic             err
);
  state_e state_q, state_d;
  logic [1:0] bcnt_q, bcnt_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [15:0] shadow_q, shadow_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [PT_W-1:0] pt_q, pt_d;
  logic bv_q, bv_d, kl_q, kl_d, err_q, err_d;
  logic acc;
  assign in_ready = state_q != HOLD;
  assign acc = in_valid && in_ready;
  assign master_key = key_q;
  assign ptext = pt_q;
  assign blk_valid = bv_q;
  assign key_loaded = kl_q;
  assign err = err_q;
  // Next-state: payload bytes shift into a shadow so outputs only change on a complete command
  always_comb begin
    state_d = state_q;
    bcnt_d = bcnt_q;
    tcnt_d = 16'd0;
    shadow_d = shadow_q;
    key_d = key_q;
    pt_d = pt_q;
    bv_d = bv_q;
    kl_d = kl_q;
    err_d = 1'b0;
    if (acc && state_q != IDLE) begin
      bcnt_d = bcnt_q + 2'd1;
      shadow_d = {shadow_q[7:0], in_data};
    end
    case (state_q)
      IDLE: begin
        bcnt_d = 2'd0;
        if (acc) begin
          if (in_data == KEY_HDR) state_d = KEY;
          else if (in_data == PT_HDR) begin
            state_d = kl_q ? PT : DROP;
            err_d = !kl_q;
          end else err_d = 1'b1;
        end
      end
      KEY: if (acc && bcnt_q == 2'd2) begin
        key_d = {shadow_q[11:0], in_data};
        kl_d = 1'b1;
        state_d = IDLE;
      end
      PT: if (acc && bcnt_q == 2'd1) begin
        pt_d = {shadow_q[7:0], in_data};
        bv_d = 1'b1;
        state_d = HOLD;
      end
      DROP: if (acc && bcnt_q == 2'd1) state_d = IDLE;
      HOLD: if (blk_ready) begin
        bv_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (TIMEOUT > 0 && !acc && (state_q == KEY || state_q == PT || state_q == DROP)) begin
      tcnt_d = tcnt_q + 16'd1;
      if (tcnt_d == 16'(TIMEOUT)) begin
        tcnt_d = 16'd0;
        state_d = IDLE;
        err_d = 1'b1;
      end
    end
  end
  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bcnt_q <= 2'd0;
      tcnt_q <= 16'd0;
      shadow_q <= 16'd0;
      key_q <= '0;
      pt_q <= '0;
      bv_q <= 1'b0;
      kl_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q <= bcnt_d;
      tcnt_q <= tcnt_d;
      shadow_q <= shadow_d;
      key_q <= key_d;
      pt_q <= pt_d;
      bv_q <= bv_d;
      kl_q <= kl_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_present_input_framer.sv
// tb_present_input_framer: directed plus randomized checks against a command-level model
module tb_present_input_framer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [19:0] master_key;
  logic [15:0] ptext;
  logic blk_valid;
  logic blk_ready = 1'b0;
  logic key_loaded;
  logic err;
  int n_vec = 0;
  int n_bad = 0;
  logic [19:0] m_key;
  logic [15:0] m_pt;
  logic m_bv, m_kl, m_err, m_hold;
  int m_cmd, m_idle;
  logic [7:0] pay[$];
  always #5 clk = ~clk;
  present_input_framer #(.KEY_HDR(8'hA5), .PT_HDR(8'h5A), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .master_key(master_key), .ptext(ptext), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .key_loaded(key_loaded), .err(err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_key = '0;
    m_pt = '0;
    m_bv = 0;
    m_kl = 0;
    m_err = 0;
    m_hold = 0;
    m_cmd = 0;
    m_idle = 0;
    pay.delete();
  endtask
  task automatic model_clock(input logic r, input logic v, input logic [7:0] d, input logic br);
    logic acc;
    logic nerr;
    int need;
    if (r) begin
      model_reset();
      return;
    end
    acc = v && !m_hold;
    nerr = 0;
    if (m_hold) begin
      if (br) begin
        m_hold = 0;
        m_bv = 0;
      end
    end else if (m_cmd == 0) begin
      if (acc) begin
        pay.delete();
        m_idle = 0;
        if (d == 8'hA5) m_cmd = 1;
        else if (d == 8'h5A) begin
          m_cmd = m_kl ? 2 : 3;
          nerr = !m_kl;
        end else nerr = 1;
      end
    end else if (acc) begin
      pay.push_back(d);
      m_idle = 0;
      need = (m_cmd == 1) ? 3 : 2;
      if (pay.size() == need) begin
        if (m_cmd == 1) begin
          m_key = {pay[0][3:0], pay[1], pay[2]};
          m_kl = 1;
        end else if (m_cmd == 2) begin
          m_pt = {pay[0], pay[1]};
          m_bv = 1;
          m_hold = 1;
        end
        m_cmd = 0;
        pay.delete();
      end
    end else begin
      m_idle++;
      if (m_idle == 16) begin
        nerr = 1;
        m_cmd = 0;
        m_idle = 0;
        pay.delete();
      end
    end
    m_err = nerr;
  endtask
  task automatic step();
    @(negedge clk);
    chk("in_ready", in_ready, !m_hold);
    chk("master_key", master_key, m_key);
    chk("ptext", ptext, m_pt);
    chk("blk_valid", blk_valid, m_bv);
    chk("key_loaded", key_loaded, m_kl);
    chk("err", err, m_err);
    @(posedge clk);
    model_clock(rst, in_valid, in_data, blk_ready);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    in_valid = 1;
    in_data = b;
    step();
    in_valid = 0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  initial begin
    model_reset();
    rst = 1;
    idle(2);
    rst = 0;
    chk("rst_key", master_key, 20'h0);
    chk("rst_ready", in_ready, 1);
    chk("rst_err", err, 0);
    send(8'hA5); send(8'h0F); send(8'h12);
    chk("key_partial", master_key, 20'h0);
    send(8'h34);
    chk("key_f1234", master_key, 20'hF1234);
    chk("key_loaded", key_loaded, 1);
    chk("key_noerr", err, 0);
    send(8'h5A); send(8'hBE);
    chk("pt_not_yet", blk_valid, 0);
    send(8'hEF);
    chk("pt_beef", ptext, 16'hBEEF);
    chk("pt_valid", blk_valid, 1);
    in_valid = 1;
    in_data = 8'h77;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_ready", in_ready, 0);
      chk("hold_pt", ptext, 16'hBEEF);
    end
    in_valid = 0;
    blk_ready = 1;
    step();
    blk_ready = 0;
    chk("hs_valid", blk_valid, 0);
    chk("hs_ready", in_ready, 1);
    rst = 1;
    step();
    rst = 0;
    send(8'h5A);
    chk("nokey_err", err, 1);
    send(8'h11);
    chk("nokey_err_once", err, 0);
    send(8'h22);
    idle(1);
    chk("nokey_bv", blk_valid, 0);
    chk("nokey_pt", ptext, 16'h0);
    send(8'h3C);
    chk("bad_hdr_err", err, 1);
    send(8'hA5);
    chk("bad_hdr_once", err, 0);
    send(8'h00); send(8'h00); send(8'h00);
    chk("zero_key", key_loaded, 1);
    send(8'hA5); send(8'h01);
    idle(15);
    chk("to_not_yet", err, 0);
    idle(1);
    chk("to_err", err, 1);
    chk("to_key", master_key, 20'h0);
    send(8'h5A); send(8'h00); send(8'h01);
    chk("to_pt", ptext, 16'h0001);
    chk("to_bv", blk_valid, 1);
    blk_ready = 1;
    step();
    blk_ready = 0;
    send(8'h5A); send(8'h44);
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_key", master_key, 20'h0);
    chk("mid_rst_kl", key_loaded, 0);
    chk("mid_rst_bv", blk_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_err", err, 0);
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      in_valid = $urandom_range(0, 3) != 0;
      in_data = r < 25 ? 8'hA5 : r < 50 ? 8'h5A : 8'($urandom);
      blk_ready = $urandom_range(0, 2) == 0;
      rst = $urandom_range(0, 599) == 0;
      step();
      if ($urandom_range(0, 99) < 2) begin
        in_valid = 0;
        rst = 0;
        idle($urandom_range(10, 20));
      end
    end
    rst = 0;
    in_valid = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/present_input_framer.md
Name: present_input_framer

Overview:
- Upstream front end for the 16-bit-block / 20-bit-key PRESENT encipher datapath.
- Receives a byte-serial command stream and assembles a 20-bit master key and 16-bit plaintext blocks.
- Presents them as registered, stable inputs to the combinational encipher, with a valid/ready handshake toward the stage that samples the ciphertext.
- Guarantees that key and plaintext never change while a block is being offered.

Parameters:
- KEY_HDR, 8'hA5, header byte that opens a key-load command (3 payload bytes follow).
- PT_HDR, 8'h5A, header byte that opens a plaintext command (2 payload bytes follow).
- TIMEOUT, 16, maximum idle cycles allowed between payload bytes; 0 disables the timeout.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  command/payload byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  a byte is accepted when in_valid and in_ready are both high.
- master_key  output  20  registered key; drives the key scheduler input.
- ptext  output  16  registered plaintext; drives the encipher input.
- blk_valid  output  1  ptext and master_key form a complete block.
- blk_ready  input  1  downstream has consumed the block.
- key_loaded  output  1  a key has been loaded since reset (sticky).
- err  output  1  one-cycle pulse on a protocol error.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state IDLE, master_key 0, ptext 0, blk_valid 0, key_loaded 0, err 0, in_ready 1, byte and timeout counters 0.
- A reset mid-command aborts the command with no err pulse.
- States: IDLE, KEY, PT, DROP, HOLD.
- in_ready is 1 in IDLE, KEY, PT and DROP; it is 0 in HOLD.
- IDLE, accepted byte == KEY_HDR: go to KEY, byte count 0.
- IDLE, accepted byte == PT_HDR:
  - key_loaded = 1: go to PT.
  - key_loaded = 0: pulse err and go to DROP, which discards the 2 payload bytes.
- IDLE, any other accepted byte: pulse err, byte dropped, remain in IDLE.
- KEY: big-endian assembly into a shadow register.
  - Byte 0 supplies key[19:16] (upper nibble ignored); byte 1 supplies key[15:8]; byte 2 supplies key[7:0].
  - On the cycle after byte 2 is accepted, master_key updates, key_loaded goes to 1, and the state returns to IDLE.
  - master_key never shows a partial key.
- PT: byte 0 supplies ptext[15:8]; byte 1 supplies ptext[7:0].
  - On the cycle after byte 1 is accepted, ptext updates, blk_valid goes to 1, and the state moves to HOLD.
  - Latency is exactly 1 cycle from the last accepted byte to blk_valid.
- HOLD: blk_valid stays high; ptext and master_key are held.
  - blk_ready = 1 in HOLD: blk_valid is 0 on the next cycle and the state returns to IDLE.
  - A new byte can be accepted on the cycle after the handshake, never in the handshake cycle itself.
  - blk_ready while not in HOLD is ignored.
- DROP: accept and discard 2 bytes, then return to IDLE; no further err pulse.
- Timeout (TIMEOUT > 0):
  - In KEY, PT and DROP, the counter increments on each cycle with no byte accepted and clears on each accepted byte.
  - When the counter reaches TIMEOUT: pulse err, return to IDLE, discard partial data. Previous master_key and ptext are kept.
  - No timeout applies in IDLE or HOLD.
- err is never held high for more than 1 cycle per event.
- Key values: a key equal to the previous key is still a valid load; all-zero key and all-zero plaintext are legal.

Decomposition:
- Shared package present_pkg holds:
  - PT_W = 16 and KEY_W = 20.
  - Default header constants KEY_HDR_DEF and PT_HDR_DEF.
  - The framer state enum.
- No sub-module is needed: a single FSM with shift/shadow registers and a timeout counter.

Test Plan:
- Reset, then send A5,0F,12,34 -> master_key = 20'hF1234 one cycle after the last byte, key_loaded = 1, no err.
- After a key load, send 5A,BE,EF -> ptext = 16'hBEEF and blk_valid = 1 exactly 1 cycle after EF. Hold blk_ready = 0 for 5 cycles -> in_ready = 0, ptext stable. Raise blk_ready -> blk_valid = 0 next cycle, in_ready = 1.
- Out of reset (no key), send 5A,11,22 -> err pulses once on the header, all 3 bytes are accepted, blk_valid stays 0, ptext stays 0.
- Send header 3C -> single err pulse, state stays IDLE; then a valid key command loads normally.
- With TIMEOUT = 16, send A5,01 then idle 16 cycles -> err pulse on the 16th idle cycle, master_key unchanged. Then 5A,00,01 -> blk_valid with ptext = 16'h0001.
- Assert rst in the middle of a PT command -> next cycle master_key = 0, key_loaded = 0, blk_valid = 0, in_ready = 1, no err pulse.
